// File: rtl/pool_2.sv
// 2x2 / stride-2 binary max-pool: one output row per clock, CH*OD clocks per frame.
// Optional build macro POOL_THRESH_EN: window = (popcount >= THRESH) instead of OR.
module pool_2 #(
   parameter int CH     = 4,
   parameter int IN_DIM = 8
`ifdef POOL_THRESH_EN
   ,
   parameter int THRESH = 2
`endif
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start_flag,
   input  logic [CH*IN_DIM*IN_DIM-1:0]           in,
   output logic [CH*(IN_DIM/2)*(IN_DIM/2)-1:0]   out,
   output logic                                  end_flag
);

   localparam int OD  = IN_DIM / 2;
   localparam int CHS = IN_DIM * IN_DIM;
   localparam int OD2 = OD * OD;
   localparam int RW  = (OD > 1) ? $clog2(OD) : 1;
   localparam int CW  = (CH > 1) ? $clog2(CH) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e                state_q, state_d;
   logic [CH*CHS-1:0]     in_q, in_d;
   logic [CH*OD2-1:0]     work_q, work_d;
   logic [CH*OD2-1:0]     out_q, out_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         ch_q, ch_d;
   logic                  end_q, end_d;

   logic [CHS-1:0]        slice;
   logic [3:0]            win_bits;
   logic                  win;
`ifdef POOL_THRESH_EN
   logic [2:0]            pop;
`endif

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      state_d  = state_q;
      in_d     = in_q;
      work_d   = work_q;
      out_d    = out_q;
      row_d    = row_q;
      ch_d     = ch_q;
      end_d    = 1'b0;
      slice    = in_q[(CH-1-int'(ch_q))*CHS +: CHS];
      win_bits = '0;
      win      = 1'b0;
`ifdef POOL_THRESH_EN
      pop      = '0;
`endif

      case (state_q)
         IDLE: begin
            if (start_flag) begin
               in_d    = in;
               row_d   = '0;
               ch_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int c = 0; c < OD; c++) begin
               win_bits = {slice[CHS-1-((2*int'(row_q))*IN_DIM + 2*c)],
                           slice[CHS-1-((2*int'(row_q))*IN_DIM + 2*c + 1)],
                           slice[CHS-1-((2*int'(row_q)+1)*IN_DIM + 2*c)],
                           slice[CHS-1-((2*int'(row_q)+1)*IN_DIM + 2*c + 1)]};
`ifdef POOL_THRESH_EN
               pop = 3'(win_bits[0]) + 3'(win_bits[1]) + 3'(win_bits[2]) + 3'(win_bits[3]);
               win = (int'(pop) >= THRESH);
`else
               win = |win_bits;
`endif
               work_d[(CH-1-int'(ch_q))*OD2 + OD2-1-(int'(row_q)*OD + c)] = win;
            end

            if (row_q == RW'(OD-1)) begin
               row_d = '0;
               // The final row is published together with the rest of the frame.
               if (ch_q == CW'(CH-1)) begin
                  out_d   = work_d;
                  end_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  ch_d = ch_q + CW'(1);
               end
            end else begin
               row_d = row_q + RW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         in_q    <= '0;
         work_q  <= '0;
         out_q   <= '0;
         row_q   <= '0;
         ch_q    <= '0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         work_q  <= work_d;
         out_q   <= out_d;
         row_q   <= row_d;
         ch_q    <= ch_d;
         end_q   <= end_d;
      end
   end

   assign out      = out_q;
   assign end_flag = end_q;

endmodule

// File: tb/tb_pool_2.sv
// Directed bench for pool_2: latency, bit mapping, ignored starts, async abort.
module tb_pool_2;

   logic         clk = 1'b0;
   logic         reset;
   logic         start_flag;
   logic [255:0] in_v;
   logic [63:0]  out_v;
   logic         end_flag;

   int checks = 0;
   int errors = 0;

   logic [255:0] v_px0, v_px255, v_mixed, v_b, v_c, v_cb;
   int           ends;

   always #5 clk = ~clk;

   pool_2 dut (
      .clk       (clk),
      .reset     (reset),
      .start_flag(start_flag),
      .in        (in_v),
      .out       (out_v),
      .end_flag  (end_flag)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; start is sampled on the next rising edge (E0).
   task automatic start_frame(input logic [255:0] v);
      in_v       = v;
      start_flag = 1'b1;
      @(negedge clk);
      start_flag = 1'b0;
   endtask

   // Counts falling edges after E0 until end_flag is seen; bounded at 40.
   task automatic wait_end(input string tag, input logic [63:0] exp);
      int n = 0;
      while (end_flag !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd16);
      check({tag, " out"}, out_v, exp);
   endtask

   task automatic idle_watch(input string tag, input int k);
      int seen = 0;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         if (end_flag === 1'b1) seen++;
      end
      check({tag, " spurious end"}, 64'(seen), 64'd0);
   endtask

   initial begin
      v_px0   = '0; v_px0[255] = 1'b1;
      v_px255 = '0; v_px255[0] = 1'b1;
      v_mixed = '0; v_mixed[170] = 1'b1; v_mixed[85] = 1'b1;
      v_b     = '0; v_b[255] = 1'b1; v_b[0] = 1'b1;
      v_c     = '1;
      v_cb    = {16{16'hAA55}};

      reset      = 1'b0;
      start_flag = 1'b0;
      in_v       = '0;
      repeat (3) @(negedge clk);
      check("reset out", out_v, 64'h0);
      check("reset end", 64'(end_flag), 64'h0);
      reset = 1'b1;
      @(negedge clk);

      start_frame('0);
      wait_end("zero", 64'h0);
      @(negedge clk);
      check("zero end width", 64'(end_flag), 64'h0);

      start_frame(v_px0);
      wait_end("px0", 64'h8000_0000_0000_0000);
      start_frame(v_px255);
      check("px0 end width", 64'(end_flag), 64'h0);
      wait_end("px255", 64'h0000_0000_0000_0001);
      @(negedge clk);

      start_frame(v_cb);
      wait_end("checker", 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);

      start_frame(v_mixed);
      wait_end("mixed", 64'h0000_0200_0040_0000);
      @(negedge clk);

      start_frame(v_b);
      ends = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 5 || k == 16) begin
            in_v       = v_c;
            start_flag = 1'b1;
         end
         @(negedge clk);
         start_flag = 1'b0;
         if (k == 8)  check("hold out E8", out_v, 64'h0000_0200_0040_0000);
         if (k == 15) check("hold out E15", out_v, 64'h0000_0200_0040_0000);
         if (k < 16 && end_flag === 1'b1) ends++;
      end
      check("ignored early end", 64'(ends), 64'd0);
      check("ignored end", 64'(end_flag), 64'h1);
      check("ignored out", out_v, 64'h8000_0000_0000_0001);
      idle_watch("ignored", 20);

      start_frame(v_c);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort out", out_v, 64'h0);
      check("abort end", 64'(end_flag), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      idle_watch("abort", 30);
      @(negedge clk);
      start_frame(v_mixed);
      wait_end("after abort", 64'h0000_0200_0040_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
